// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the N-port data-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a port index; a single-bit index is kept even for degenerate sizes.
  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the arbiter: per-port request/write lanes and the shared read return.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotating priority picker: first set request strictly after i_start, with wrap.
module rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_start,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);
  int w_dist;
  int w_best;

  // Distance 0 is the port right after i_start; the smallest distance wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_dist = 0;
    w_best = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = (i + NUM_PORTS - 1 - int'(i_start)) % NUM_PORTS;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(i);
      end
    end
    if (w_best < NUM_PORTS) begin
      o_any = 1'b1;
      o_gnt = NUM_PORTS'(1) << o_idx;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between NUM_PORTS requesters and routes read data
// back to the issuing port after a fixed pipelined read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int RR_MODE      = ARB_FIXED
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                force_en,
  input  logic [port_idx_w(NUM_PORTS)-1:0]    force_sel,
  mem_port_arbiter_if.slave                   bus,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  output logic                                mem_we,
  input  logic [DATA_W-1:0]                   mem_rdata
);
  localparam int              IDX_W    = port_idx_w(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [IDX_W-1:0]     w_start;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_any;
  logic                 w_rd_xfer;
  logic [ADDR_W-1:0]    w_addr_sel;
  logic [DATA_W-1:0]    w_wdata_sel;

  logic [IDX_W-1:0]     r_last_ptr;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_mem_we;
  logic [READ_LATENCY:0] r_vld_p;
  logic [IDX_W-1:0]     r_idx_p [READ_LATENCY+1];

  // Grants are suppressed while reset is held so the bus is quiet during reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      w_elig[i] = rst_n & bus.req[i] & (~force_en | (force_sel == IDX_W'(i)));
  end

  assign w_start = (RR_MODE == ARB_RR) ? r_last_ptr : LAST_IDX;

  rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign bus.gnt     = w_gnt;
  assign w_rd_xfer   = w_any & ~bus.we[w_idx];
  assign w_addr_sel  = bus.addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_wdata_sel = bus.wdata[int'(w_idx)*DATA_W +: DATA_W];

  // Stage p0: memory request registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_last_ptr  <= LAST_IDX;
    end else begin
      r_mem_we <= w_any & bus.we[w_idx];
      if (w_any) begin
        r_mem_addr  <= w_addr_sel;
        r_mem_wdata <= w_wdata_sel;
        r_last_ptr  <= w_idx;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

  // Stages p0..pREAD_LATENCY: read tag shift register, aligned with mem_rdata at the exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p <= '0;
    else        r_vld_p <= {r_vld_p[READ_LATENCY-1:0], w_rd_xfer};
  end

  always_ff @(posedge clk) begin
    r_idx_p[0] <= w_idx;
    for (int s = 1; s <= READ_LATENCY; s++)
      r_idx_p[s] <= r_idx_p[s-1];
  end

  always_comb begin
    bus.rvalid = '0;
    if (r_vld_p[READ_LATENCY]) bus.rvalid[r_idx_p[READ_LATENCY]] = 1'b1;
  end

  assign bus.rdata = r_vld_p[READ_LATENCY] ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a 2-port fixed-priority instance (latency 1) and a 4-port round-robin instance (latency 3).
module tb_mem_port_arbiter;
  typedef struct { int port; logic [31:0] data; int due; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) a_if();
  mem_port_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) b_if();

  logic        a_fen, b_fen;
  logic        a_fsel;
  logic [1:0]  b_fsel;
  logic [31:0] a_maddr, a_mwdata, a_mrdata;
  logic [31:0] b_maddr, b_mwdata, b_mrdata;
  logic        a_mwe, b_mwe;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .RR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .force_en(a_fen), .force_sel(a_fsel), .bus(a_if),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_we(a_mwe), .mem_rdata(a_mrdata));

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .RR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .force_en(b_fen), .force_sel(b_fsel), .bus(b_if),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_we(b_mwe), .mem_rdata(b_mrdata));

  // Memory models: unwritten words read as 0xC0DE_<addr[15:0]>.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  bit   [255:0] wf_a = '0;
  bit   [255:0] wf_b = '0;
  logic [31:0] rd_a, rd_b0, rd_b1, rd_b2;

  always @(posedge clk) begin
    if (a_mwe) begin
      mem_a[a_maddr[7:0]] <= a_mwdata;
      wf_a[a_maddr[7:0]]  <= 1'b1;
    end
    rd_a <= wf_a[a_maddr[7:0]] ? mem_a[a_maddr[7:0]] : pat(a_maddr);
  end
  assign a_mrdata = rd_a;

  always @(posedge clk) begin
    if (b_mwe) begin
      mem_b[b_maddr[7:0]] <= b_mwdata;
      wf_b[b_maddr[7:0]]  <= 1'b1;
    end
    rd_b0 <= wf_b[b_maddr[7:0]] ? mem_b[b_maddr[7:0]] : pat(b_maddr);
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
  end
  assign b_mrdata = rd_b2;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p; e.data = d; e.due = cyc + 2;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p; e.data = d; e.due = cyc + 4;
    q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    if (a_if.rvalid != '0) begin
      if (q_a.size() == 0) chk("a_unexpected_rvalid", 64'(a_if.rvalid), 64'h0);
      else begin
        ea = q_a.pop_front();
        chk("a_rvalid_port", 64'(a_if.rvalid), 64'h1 << ea.port);
        chk("a_rdata", 64'(a_if.rdata), 64'(ea.data));
        chk("a_rvalid_cycle", 64'(cyc), 64'(ea.due));
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.rvalid != '0) begin
      if (q_b.size() == 0) chk("b_unexpected_rvalid", 64'(b_if.rvalid), 64'h0);
      else begin
        eb = q_b.pop_front();
        chk("b_rvalid_port", 64'(b_if.rvalid), 64'h1 << eb.port);
        chk("b_rdata", 64'(b_if.rdata), 64'(eb.data));
        chk("b_rvalid_cycle", 64'(cyc), 64'(eb.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lp, gi, p;
    logic [3:0] elig, expg;
    a_if.req = '0; a_if.we = '0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = '0; b_if.we = '0; b_if.addr = '0; b_if.wdata = '0;
    a_fen = 1'b0; a_fsel = 1'b0; b_fen = 1'b0; b_fsel = 2'd0;
    repeat (2) nxt();

    // Reset state, with requests asserted
    a_if.req = '1; b_if.req = '1;
    @(negedge clk);
    chk("rst_a_gnt", 64'(a_if.gnt), 64'h0);
    chk("rst_b_gnt", 64'(b_if.gnt), 64'h0);
    chk("rst_a_mem_we", 64'(a_mwe), 64'h0);
    chk("rst_a_mem_addr", 64'(a_maddr), 64'h0);
    chk("rst_a_mem_wdata", 64'(a_mwdata), 64'h0);
    chk("rst_a_rvalid", 64'(a_if.rvalid), 64'h0);
    chk("rst_a_rdata", 64'(a_if.rdata), 64'h0);
    chk("rst_b_mem_we", 64'(b_mwe), 64'h0);
    nxt();
    a_if.req = '0; b_if.req = '0; rst_n = 1'b1;
    nxt();

    // Fixed priority: both ports read, port 0 always wins
    a_if.addr = {32'h20, 32'h10};
    a_if.req  = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_fixed_gnt", 64'(a_if.gnt), 64'h1);
      push_a(0, 32'hC0DE_0010);
      if (k > 0) chk("a_fixed_mem_addr", 64'(a_maddr), 64'h10);
      nxt();
    end
    a_if.req = 2'b10;
    @(negedge clk);
    chk("a_p1_gnt", 64'(a_if.gnt), 64'h2);
    push_a(1, 32'hC0DE_0020);
    nxt();

    // Write from port 1, then read the same word from port 0
    a_if.we = 2'b10; a_if.addr = {32'h8, 32'h8}; a_if.wdata = {32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    chk("a_wr_gnt", 64'(a_if.gnt), 64'h2);
    chk("a_p1_mem_addr", 64'(a_maddr), 64'h20);
    chk("a_p1_mem_we", 64'(a_mwe), 64'h0);
    nxt();
    a_if.req = 2'b01; a_if.we = 2'b00;
    @(negedge clk);
    chk("a_rd_gnt", 64'(a_if.gnt), 64'h1);
    chk("a_wr_mem_we", 64'(a_mwe), 64'h1);
    chk("a_wr_mem_addr", 64'(a_maddr), 64'h8);
    chk("a_wr_mem_wdata", 64'(a_mwdata), 64'hDEAD_BEEF);
    push_a(0, 32'hDEAD_BEEF);
    nxt();
    a_if.req = 2'b00;
    @(negedge clk);
    chk("a_wr_mem_we_once", 64'(a_mwe), 64'h0);
    nxt();

    // Forced port selection
    a_if.addr = {32'h20, 32'h10}; a_if.req = 2'b11; a_fen = 1'b1; a_fsel = 1'b1;
    @(negedge clk);
    chk("a_force_gnt", 64'(a_if.gnt), 64'h2);
    push_a(1, 32'hC0DE_0020);
    nxt();
    a_fen = 1'b0;
    @(negedge clk);
    chk("a_unforce_gnt", 64'(a_if.gnt), 64'h1);
    push_a(0, 32'hC0DE_0010);
    nxt();
    a_fen = 1'b1; a_if.req = 2'b01;
    @(negedge clk);
    chk("a_force_blocked_gnt", 64'(a_if.gnt), 64'h0);
    nxt();
    a_fen = 1'b0; a_if.req = 2'b00;
    repeat (4) nxt();

    // Round-robin with all four ports requesting
    b_if.addr = {32'h4C, 32'h48, 32'h44, 32'h40};
    b_if.req  = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_rr_gnt", 64'(b_if.gnt), 64'h1 << (k % 4));
      push_b(k % 4, 32'hC0DE_0040 + 32'(4 * (k % 4)));
      nxt();
    end
    b_if.req = 4'h0;
    repeat (5) nxt();

    // Reset one cycle after a read: that read must never return
    b_if.req = 4'b0010;
    @(negedge clk);
    chk("b_pre_rst_gnt", 64'(b_if.gnt), 64'h2);
    nxt();
    b_if.req = 4'h0;
    nxt();
    rst_n = 1'b0; b_if.req = 4'hF;
    @(negedge clk);
    chk("mid_rst_b_gnt", 64'(b_if.gnt), 64'h0);
    chk("mid_rst_b_mem_we", 64'(b_mwe), 64'h0);
    chk("mid_rst_b_mem_addr", 64'(b_maddr), 64'h0);
    chk("mid_rst_b_rvalid", 64'(b_if.rvalid), 64'h0);
    chk("mid_rst_b_rdata", 64'(b_if.rdata), 64'h0);
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_post_rst_gnt", 64'(b_if.gnt), 64'h1 << k);
      push_b(k, 32'hC0DE_0040 + 32'(4 * k));
      nxt();
    end

    // Random requests with withdrawals and occasional forcing
    lp = 3;
    for (int k = 0; k < 30; k++) begin
      b_if.req = 4'($urandom);
      b_fen    = ($urandom_range(0, 3) == 0);
      b_fsel   = 2'($urandom);
      @(negedge clk);
      elig = b_if.req & (b_fen ? (4'b0001 << b_fsel) : 4'hF);
      expg = 4'h0; gi = 0;
      for (int j = 1; j <= 4; j++) begin
        p = (lp + j) % 4;
        if (expg == 4'h0 && elig[p[1:0]]) begin
          expg = 4'b0001 << p[1:0];
          gi   = p;
        end
      end
      chk("b_rnd_gnt", 64'(b_if.gnt), 64'(expg));
      if (expg != 4'h0) begin
        lp = gi;
        push_b(gi, 32'hC0DE_0040 + 32'(4 * gi));
      end
      nxt();
    end
    b_if.req = 4'h0; b_fen = 1'b0;
    repeat (8) nxt();

    chk("a_all_reads_returned", 64'(q_a.size()), 64'h0);
    chk("b_all_reads_returned", 64'(q_b.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
